// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Tracks in-flight predicted branches in program order and
//                resolves the oldest one against its actual direction.
//                Produces a predictor-update strobe, a one-cycle flush
//                request with the corrected fetch PC, and resolution
//                statistics.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH  : number of in-flight prediction entries (power of two, >= 2)
//    CNT_W  : width of the statistics counters
//  Ports
//    clk, rst_n             : clock, asynchronous active-low reset
//    pred_valid/taken/pc/target : new prediction from decode
//    pred_ready             : an entry is free (occupancy < DEPTH)
//    res_valid/res_taken    : resolution of the oldest in-flight branch
//    branch_mem_sig         : one-cycle predictor-update strobe
//    actual_branch_decision : resolved direction (held between strobes)
//    update_branch_addr     : PC of the resolved branch (held)
//    mispredict             : one-cycle flush request
//    recovery_pc            : corrected fetch PC (valid with mispredict)
//    branch_count           : resolved branches, saturating
//    mispredict_count       : mispredictions, saturating
//    res_error              : sticky, resolution seen with nothing in flight
// ============================================================================
module branch_resolve_unit #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pred_valid,
   input  logic              pred_taken,
   input  logic [31:0]       pred_pc,
   input  logic [31:0]       pred_target,
   output logic              pred_ready,
   input  logic              res_valid,
   input  logic              res_taken,
   output logic              branch_mem_sig,
   output logic              actual_branch_decision,
   output logic [31:0]       update_branch_addr,
   output logic              mispredict,
   output logic [31:0]       recovery_pc,
   output logic [CNT_W-1:0]  branch_count,
   output logic [CNT_W-1:0]  mispredict_count,
   output logic              res_error
);

   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]   C_FULL  = (PW+1)'(DEPTH);

   // Entry storage; contents are only meaningful below the occupancy count,
   // so it needs no reset.
   logic [31:0]      pc_mem_q    [DEPTH];
   logic [31:0]      tgt_mem_q   [DEPTH];
   logic             taken_mem_q [DEPTH];

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   // One bit wider than the pointers so full (DEPTH) and empty (0) differ.
   logic [PW:0]      count_q,  count_d;

   logic             branch_mem_sig_q, branch_mem_sig_d;
   logic             actual_q,         actual_d;
   logic [31:0]      upd_addr_q,       upd_addr_d;
   logic             mispredict_q,     mispredict_d;
   logic [31:0]      recovery_pc_q,    recovery_pc_d;
   logic [CNT_W-1:0] br_cnt_q,         br_cnt_d;
   logic [CNT_W-1:0] mp_cnt_q,         mp_cnt_d;
   logic             res_error_q,      res_error_d;

   logic             push_req;
   logic             pop;
   logic             res_err;
   logic             mis;
   logic             push;
   logic [31:0]      head_pc;
   logic [31:0]      head_tgt;
   logic             head_taken;

   assign pred_ready = (count_q < C_FULL);

   assign head_pc    = pc_mem_q[rd_ptr_q];
   assign head_tgt   = tgt_mem_q[rd_ptr_q];
   assign head_taken = taken_mem_q[rd_ptr_q];

   assign push_req = pred_valid & pred_ready;
   assign pop      = res_valid & (count_q != '0);
   assign res_err  = res_valid & (count_q == '0);
   assign mis      = pop & (res_taken != head_taken);
   // A mispredict flushes everything younger, including a same-edge push;
   // an erroneous resolution freezes all state, including the push.
   assign push     = push_req & ~mis & ~res_err;

   always_comb begin
      rd_ptr_d         = rd_ptr_q;
      wr_ptr_d         = wr_ptr_q;
      count_d          = count_q;
      branch_mem_sig_d = pop;
      actual_d         = actual_q;
      upd_addr_d       = upd_addr_q;
      mispredict_d     = mis;
      recovery_pc_d    = recovery_pc_q;
      br_cnt_d         = br_cnt_q;
      mp_cnt_d         = mp_cnt_q;
      res_error_d      = res_error_q | res_err;

      if (mis) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      if (pop) begin
         actual_d   = res_taken;
         upd_addr_d = head_pc;
         if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
      end

      if (mis) begin
         recovery_pc_d = res_taken ? head_tgt : (head_pc + 32'd4);
         if (mp_cnt_q != '1) mp_cnt_d = mp_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= pred_pc;
         tgt_mem_q[wr_ptr_q]   <= pred_target;
         taken_mem_q[wr_ptr_q] <= pred_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
         branch_mem_sig_q <= 1'b0;
         actual_q         <= 1'b0;
         upd_addr_q       <= '0;
         mispredict_q     <= 1'b0;
         recovery_pc_q    <= '0;
         br_cnt_q         <= '0;
         mp_cnt_q         <= '0;
         res_error_q      <= 1'b0;
      end else begin
         rd_ptr_q         <= rd_ptr_d;
         wr_ptr_q         <= wr_ptr_d;
         count_q          <= count_d;
         branch_mem_sig_q <= branch_mem_sig_d;
         actual_q         <= actual_d;
         upd_addr_q       <= upd_addr_d;
         mispredict_q     <= mispredict_d;
         recovery_pc_q    <= recovery_pc_d;
         br_cnt_q         <= br_cnt_d;
         mp_cnt_q         <= mp_cnt_d;
         res_error_q      <= res_error_d;
      end
   end

   assign branch_mem_sig         = branch_mem_sig_q;
   assign actual_branch_decision = actual_q;
   assign update_branch_addr     = upd_addr_q;
   assign mispredict             = mispredict_q;
   assign recovery_pc            = recovery_pc_q;
   assign branch_count           = br_cnt_q;
   assign mispredict_count       = mp_cnt_q;
   assign res_error              = res_error_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Directed self-checking bench for branch_resolve_unit
//                (DEPTH=4, CNT_W=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

   logic        clk;
   logic        rst_n;
   logic        pred_valid;
   logic        pred_taken;
   logic [31:0] pred_pc;
   logic [31:0] pred_target;
   logic        pred_ready;
   logic        res_valid;
   logic        res_taken;
   logic        branch_mem_sig;
   logic        actual_branch_decision;
   logic [31:0] update_branch_addr;
   logic        mispredict;
   logic [31:0] recovery_pc;
   logic [31:0] branch_count;
   logic [31:0] mispredict_count;
   logic        res_error;

   int n_total;
   int n_pass;

   branch_resolve_unit #(.DEPTH(4), .CNT_W(32)) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .pred_valid             (pred_valid),
      .pred_taken             (pred_taken),
      .pred_pc                (pred_pc),
      .pred_target            (pred_target),
      .pred_ready             (pred_ready),
      .res_valid              (res_valid),
      .res_taken              (res_taken),
      .branch_mem_sig         (branch_mem_sig),
      .actual_branch_decision (actual_branch_decision),
      .update_branch_addr     (update_branch_addr),
      .mispredict             (mispredict),
      .recovery_pc            (recovery_pc),
      .branch_count           (branch_count),
      .mispredict_count       (mispredict_count),
      .res_error              (res_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Advance one rising edge, then settle 1 time unit before sampling/driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      pred_valid  = 1'b1;
      pred_pc     = pc;
      pred_taken  = tk;
      pred_target = tgt;
   endtask

   task automatic idle();
      pred_valid = 1'b0;
      res_valid  = 1'b0;
   endtask

   initial begin
      n_total     = 0;
      n_pass      = 0;
      rst_n       = 1'b0;
      pred_valid  = 1'b0;
      pred_taken  = 1'b0;
      pred_pc     = '0;
      pred_target = '0;
      res_valid   = 1'b0;
      res_taken   = 1'b0;

      // ---- Reset state ----
      #2;
      chk("rst_ready",   32'(pred_ready), 32'd1);
      chk("rst_strobe",  32'(branch_mem_sig), 32'd0);
      chk("rst_addr",    update_branch_addr, 32'h0);
      chk("rst_recpc",   recovery_pc, 32'h0);
      chk("rst_bcnt",    branch_count, 32'd0);
      chk("rst_err",     32'(res_error), 32'd0);
      #10 rst_n = 1'b1;
      tick();

      // ---- Correct predict-taken ----
      push(32'h100, 1'b1, 32'h140);
      tick();
      idle();
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      idle();
      chk("t1_strobe", 32'(branch_mem_sig), 32'd1);
      chk("t1_addr",   update_branch_addr, 32'h100);
      chk("t1_dec",    32'(actual_branch_decision), 32'd1);
      chk("t1_mis",    32'(mispredict), 32'd0);
      chk("t1_bcnt",   branch_count, 32'd1);
      tick();
      chk("t1_strobe_off", 32'(branch_mem_sig), 32'd0);
      chk("t1_addr_hold",  update_branch_addr, 32'h100);

      // ---- Mispredict (predicted taken, actually not taken) ----
      push(32'h200, 1'b1, 32'h260);
      tick();
      push(32'h210, 1'b0, 32'h300);
      tick();
      // Same-edge push must be discarded by the flush.
      push(32'h999, 1'b0, 32'h0);
      res_valid = 1'b1; res_taken = 1'b0;
      tick();
      idle();
      chk("t2_mis",    32'(mispredict), 32'd1);
      chk("t2_recpc",  recovery_pc, 32'h204);
      chk("t2_ready",  32'(pred_ready), 32'd1);
      chk("t2_mcnt",   mispredict_count, 32'd1);
      chk("t2_bcnt",   branch_count, 32'd2);
      chk("t2_addr",   update_branch_addr, 32'h200);
      tick();
      chk("t2_mis_off", 32'(mispredict), 32'd0);

      // ---- Fill to full; FIFO must have been empty after the flush ----
      for (int i = 0; i < 4; i++) begin
         push(32'h1000 + 32'(4*i), 1'b0, 32'hdead0000);
         tick();
         if (i == 2) chk("t3_ready_3", 32'(pred_ready), 32'd1);
      end
      chk("t3_full", 32'(pred_ready), 32'd0);
      push(32'h2000, 1'b0, 32'h0);   // dropped: FIFO full
      tick();
      chk("t3_still_full", 32'(pred_ready), 32'd0);
      // Pop with pred_valid asserted: no push (pred_ready was 0).
      push(32'h3000, 1'b0, 32'h0);
      res_valid = 1'b1; res_taken = 1'b0;
      tick();
      idle();
      chk("t3_pop_addr", update_branch_addr, 32'h1000);
      chk("t3_ready_after", 32'(pred_ready), 32'd1);
      for (int i = 1; i < 4; i++) begin
         res_valid = 1'b1; res_taken = 1'b0;
         tick();
         idle();
         chk("t3_drain_addr", update_branch_addr, 32'h1000 + 32'(4*i));
      end
      chk("t3_bcnt", branch_count, 32'd6);

      // ---- Resolve with empty FIFO ----
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      idle();
      chk("t4_err",    32'(res_error), 32'd1);
      chk("t4_strobe", 32'(branch_mem_sig), 32'd0);
      chk("t4_bcnt",   branch_count, 32'd6);
      chk("t4_mcnt",   mispredict_count, 32'd1);
      tick();
      chk("t4_err_sticky", 32'(res_error), 32'd1);

      // ---- Mispredict toward the taken target ----
      push(32'h500, 1'b0, 32'h580);
      tick();
      idle();
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      idle();
      chk("t5_mis",   32'(mispredict), 32'd1);
      chk("t5_recpc", recovery_pc, 32'h580);
      chk("t5_mcnt",  mispredict_count, 32'd2);

      // ---- Pointer wrap: 12 resolutions, pushes overlapped with pops ----
      push(32'h4000, 1'b0, 32'h0);
      tick();
      for (int k = 1; k <= 12; k++) begin
         if (k < 12) push(32'h4000 + 32'(4*k), k[0], 32'h8000);
         else        pred_valid = 1'b0;
         res_valid = 1'b1; res_taken = (k - 1) % 2 == 1;
         tick();
         idle();
         chk("t6_addr", update_branch_addr, 32'h4000 + 32'(4*(k-1)));
         chk("t6_mis",  32'(mispredict), 32'd0);
      end
      chk("t6_bcnt", branch_count, 32'd19);

      // ---- Asynchronous reset with 3 entries in flight ----
      for (int i = 0; i < 3; i++) begin
         push(32'h6000 + 32'(4*i), 1'b1, 32'h7000);
         tick();
      end
      idle();
      #3 rst_n = 1'b0;
      #1;
      chk("t7_bcnt",  branch_count, 32'd0);
      chk("t7_mcnt",  mispredict_count, 32'd0);
      chk("t7_err",   32'(res_error), 32'd0);
      chk("t7_addr",  update_branch_addr, 32'h0);
      chk("t7_recpc", recovery_pc, 32'h0);
      chk("t7_ready", 32'(pred_ready), 32'd1);
      #2 rst_n = 1'b1;
      tick();
      push(32'h100, 1'b1, 32'h140);
      tick();
      idle();
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      idle();
      chk("t7_post_strobe", 32'(branch_mem_sig), 32'd1);
      chk("t7_post_addr",   update_branch_addr, 32'h100);
      chk("t7_post_bcnt",   branch_count, 32'd1);
      // Pre-reset entries must be gone: the next resolve is an error.
      res_valid = 1'b1; res_taken = 1'b1;
      tick();
      idle();
      chk("t7_discard_err", 32'(res_error), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, the number of in-flight prediction entries (power of two, minimum 2).
REQ-002 SHALL have parameter CNT_W, default 32, the width of each statistics counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-005 SHALL have port pred_valid, input, 1, decode issues a predicted branch this cycle.
REQ-006 SHALL have port pred_taken, input, 1, the predicted direction from the predictor.
REQ-007 SHALL have port pred_pc, input, 32, the PC of the predicted branch.
REQ-008 SHALL have port pred_target, input, 32, the computed taken target.
REQ-009 SHALL have port pred_ready, output, 1, an entry is free for a new prediction.
REQ-010 SHALL have port res_valid, input, 1, the oldest in-flight branch is resolved this cycle.
REQ-011 SHALL have port res_taken, input, 1, the actual direction of the resolved branch.
REQ-012 SHALL have port branch_mem_sig, output, 1, a one-cycle predictor-update strobe.
REQ-013 SHALL have port actual_branch_decision, output, 1, the resolved direction accompanying the strobe.
REQ-014 SHALL have port update_branch_addr, output, 32, the PC of the resolved branch, for table indexing.
REQ-015 SHALL have port mispredict, output, 1, a one-cycle pipeline flush request.
REQ-016 SHALL have port recovery_pc, output, 32, the corrected fetch PC, valid while mispredict=1.
REQ-017 SHALL have port branch_count, output, CNT_W, the total number of resolved branches.
REQ-018 SHALL have port mispredict_count, output, CNT_W, the total number of mispredictions.
REQ-019 SHALL have port res_error, output, 1, a sticky flag: resolution arrived with no entry in flight.

Function
REQ-020 SHALL hold in-flight entries {pc, taken, target} in a FIFO of DEPTH entries, in program order.
REQ-021 SHALL drive pred_ready = (occupancy < DEPTH) combinationally from current occupancy only, with no same-cycle pop bypass.
REQ-022 SHALL push an entry on an edge where pred_valid=1 and pred_ready=1; pred_valid with pred_ready=0 is dropped with no state change.
REQ-023 SHALL pop the head entry on an edge where res_valid=1 and occupancy>0.
REQ-024 SHALL, when push and pop occur on the same edge without a mispredict, perform both, leaving occupancy unchanged.
REQ-025 SHALL wrap read and write pointers modulo DEPTH and track occupancy 0..DEPTH without aliasing full and empty.
REQ-026 SHALL, on a pop, register at the same edge: branch_mem_sig=1, actual_branch_decision=res_taken, update_branch_addr=head.pc; latency is 1 cycle.
REQ-027 SHALL deassert branch_mem_sig on the next edge unless another pop occurs; actual_branch_decision and update_branch_addr hold their last values.
REQ-028 SHALL, on a pop where res_taken != head.taken, register mispredict=1 for exactly one cycle.
REQ-029 SHALL set recovery_pc to head.target when res_taken=1, and to head.pc+4 (mod 2^32) when res_taken=0.
REQ-030 SHALL, on a mispredicting pop, empty the FIFO (younger entries are wrong-path) and discard any same-edge push.
REQ-031 SHALL increment branch_count on every pop and mispredict_count on every mispredicting pop, both saturating at all-ones.
REQ-032 SHALL, when res_valid=1 and occupancy=0, set res_error=1 (sticky) with no strobe, no counter change and no state change; this holds even if a push occurs on the same edge.
REQ-033 SHALL treat res_taken and pred_* as don't-care when their valid signal is 0.

Reset
REQ-034 SHALL, while rst_n=0, immediately force: FIFO empty, pred_ready=1, branch_mem_sig=0, actual_branch_decision=0, update_branch_addr=0, mispredict=0, recovery_pc=0, both counters=0, res_error=0.
REQ-035 SHALL discard in-flight entries on reset mid-operation and resume normal operation on the first rising edge after rst_n rises.

Verification
REQ-036 Push {pc=0x100, taken=1, target=0x140}; resolve res_taken=1 -> next cycle branch_mem_sig=1, update_branch_addr=0x100, mispredict=0, branch_count=1.
REQ-037 Push {0x200, taken=1, target=0x260}, then {0x210, 0, 0x300}; resolve res_taken=0 -> mispredict=1, recovery_pc=0x204, FIFO empty, pred_ready=1, mispredict_count=1.
REQ-038 Push 4 entries with DEPTH=4 -> pred_ready=0; a 5th push is dropped; on a simultaneous pop with pred_valid=1, only the pop occurs and occupancy becomes 3.
REQ-039 Resolve with FIFO empty -> res_error=1 and stays 1; branch_mem_sig=0; counters unchanged.
REQ-040 Assert rst_n=0 with 3 entries in flight, mid-cycle -> all outputs reach reset values without waiting for a clock edge; after release, the first push and resolve behave as in REQ-036.
REQ-041 Run 12 push/pop pairs at DEPTH=4 with no mispredicts -> pointers wrap and update_branch_addr sequence matches push order.
